// File: rtl/vuart_dev_streamer_pkg.sv
// Shared register map of the virtual UART device port and the streamer's FSM encoding.
package vuart_dev_streamer_pkg;

  localparam logic [15:0] VUART_ADDR_STAT    = 16'h0000;
  localparam logic [15:0] VUART_ADDR_FIFO    = 16'h0008;
  localparam int unsigned VUART_BIT_RXVLD    = 0;
  localparam int unsigned VUART_BIT_TXRDY    = 1;
  localparam int unsigned VUART_BIT_HOSTCONN = 2;
  localparam int unsigned VUART_POLL_GAP     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STAT_S,
    ST_STAT_A,
    ST_WR_S,
    ST_WR_A,
    ST_RD_S,
    ST_RD_A
  } state_t;

  function automatic logic [31:0] fifo_word(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage

// File: rtl/vuart_dev_streamer_if.sv
// APB bus between the streamer (master) and the virtual UART device port (slave).
interface vuart_dev_streamer_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/vuart_dev_streamer.sv
// APB master that polls the virtual UART STAT register and moves bytes between
// one-entry TX/RX buffers on the client side and the device FIFO register.
module vuart_dev_streamer
  import vuart_dev_streamer_pkg::*;
#(
  parameter logic [15:0] ADDR_STAT    = VUART_ADDR_STAT,
  parameter logic [15:0] ADDR_FIFO    = VUART_ADDR_FIFO,
  parameter int unsigned BIT_RXVLD    = VUART_BIT_RXVLD,
  parameter int unsigned BIT_TXRDY    = VUART_BIT_TXRDY,
  parameter int unsigned BIT_HOSTCONN = VUART_BIT_HOSTCONN,
  parameter int unsigned POLL_GAP     = VUART_POLL_GAP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [7:0]           tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [7:0]           rx_data,
  output logic                 hostconn,
  output logic                 err,
  vuart_dev_streamer_if.master apb
);

  localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);

  state_t             state, state_nx;
  logic [GAP_W-1:0]   gap, gap_nx;
  logic               turn, turn_nx;
  logic               last_tx, last_tx_nx;

  logic               tx_full;
  logic [7:0]         tx_byte;
  logic [15:0]        paddr_q;
  logic               pwrite_q;
  logic [31:0]        pwdata_q;

  logic               sel, en;
  logic               load_stat, load_wr, load_rd;
  logic               hc_cap, tx_clr, rx_load, err_nx;
  logic               do_tx, do_rx;
  logic               unused_prdata;

  assign tx_ready    = !tx_full;
  assign apb.psel    = sel;
  assign apb.penable = en;
  assign apb.paddr   = paddr_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;

  assign do_tx         = apb.prdata[BIT_TXRDY] && tx_full;
  assign do_rx         = apb.prdata[BIT_RXVLD] && !rx_valid;
  assign unused_prdata = ^apb.prdata[31:8];

  // turn holds psel low for one cycle in a SETUP state that directly follows
  // a completion, so transfers are never back-to-back.
  always_comb begin
    state_nx   = state;
    gap_nx     = gap;
    turn_nx    = turn;
    last_tx_nx = last_tx;
    sel        = 1'b0;
    en         = 1'b0;
    load_stat  = 1'b0;
    load_wr    = 1'b0;
    load_rd    = 1'b0;
    hc_cap     = 1'b0;
    tx_clr     = 1'b0;
    rx_load    = 1'b0;
    err_nx     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gap == '0 && (tx_full || !rx_valid)) begin
          state_nx  = ST_STAT_S;
          load_stat = 1'b1;
        end else if (gap != '0) begin
          gap_nx = gap - 1'b1;
        end
      end
      ST_STAT_S, ST_WR_S, ST_RD_S: begin
        if (turn) begin
          turn_nx = 1'b0;
        end else begin
          sel = 1'b1;
          case (state)
            ST_STAT_S: state_nx = ST_STAT_A;
            ST_WR_S:   state_nx = ST_WR_A;
            default:   state_nx = ST_RD_A;
          endcase
        end
      end
      ST_STAT_A, ST_WR_A, ST_RD_A: begin
        sel = 1'b1;
        en  = 1'b1;
        if (apb.pready) begin
          if (apb.pslverr) begin
            err_nx   = 1'b1;
            state_nx = ST_IDLE;
            gap_nx   = GAP_W'(POLL_GAP);
          end else if (state == ST_STAT_A) begin
            hc_cap = 1'b1;
            if (do_tx && (!do_rx || !last_tx)) begin
              state_nx = ST_WR_S;
              load_wr  = 1'b1;
              turn_nx  = 1'b1;
            end else if (do_rx) begin
              state_nx = ST_RD_S;
              load_rd  = 1'b1;
              turn_nx  = 1'b1;
            end else begin
              state_nx = ST_IDLE;
              gap_nx   = GAP_W'(POLL_GAP);
            end
          end else begin
            tx_clr     = (state == ST_WR_A);
            rx_load    = (state == ST_RD_A);
            last_tx_nx = (state == ST_WR_A);
            state_nx   = ST_STAT_S;
            load_stat  = 1'b1;
            turn_nx    = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gap     <= '0;
      turn    <= 1'b0;
      last_tx <= 1'b0;
    end else begin
      state   <= state_nx;
      gap     <= gap_nx;
      turn    <= turn_nx;
      last_tx <= last_tx_nx;
    end
  end

  // Client buffers, status capture and APB address/data, held from SETUP to completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_full  <= 1'b0;
      tx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      hostconn <= 1'b0;
      err      <= 1'b0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      err <= err_nx;
      if (hc_cap) hostconn <= apb.prdata[BIT_HOSTCONN];
      if (tx_clr) begin
        tx_full <= 1'b0;
      end else if (tx_valid && !tx_full) begin
        tx_full <= 1'b1;
        tx_byte <= tx_data;
      end
      if (rx_load) begin
        rx_valid <= 1'b1;
        rx_data  <= apb.prdata[7:0];
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (load_stat) begin
        paddr_q  <= ADDR_STAT;
        pwrite_q <= 1'b0;
      end
      if (load_wr) begin
        paddr_q  <= ADDR_FIFO;
        pwrite_q <= 1'b1;
        pwdata_q <= fifo_word(tx_byte);
      end
      if (load_rd) begin
        paddr_q  <= ADDR_FIFO;
        pwrite_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vuart_dev_streamer.sv
// Bench: behavioural APB slave plus a transaction-level model of the streamer's buffers and polling rules.
module tb_vuart_dev_streamer;
  import vuart_dev_streamer_pkg::*;

  localparam int POLL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, hostconn, err;
  logic [7:0] tx_data, rx_data;

  vuart_dev_streamer_if bus();

  vuart_dev_streamer #(.POLL_GAP(POLL)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .hostconn(hostconn), .err(err), .apb(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus configuration (written by the main sequence)
  logic [2:0] stat_val = 3'd0;
  bit         stat_rand = 0;
  logic [7:0] rd_byte = 8'h00;
  bit         rd_rand = 0;
  int         wait_fixed = 0;
  int         err_rate = 0;
  bit         err_wr_once = 0;
  int         rx_mode = 1;
  bit         tx_rand = 0;
  bit         quiet = 0;
  logic [7:0] src_q[$];

  // Reference model state and observations
  bit         tx_pend, rx_held, hc_m, err_exp, last_tx_m;
  logic [7:0] tx_byte_m, rx_byte_m;
  int         exp_op;
  bit         prev_psel, prev_done;
  int         last_stat_cyc;
  int         cyc = 0;
  int         stat_cnt = 0, rd_cnt = 0, err_cnt = 0;
  logic [7:0] wr_q[$];
  int         ops_q[$];

  task automatic model_reset();
    tx_pend = 0; rx_held = 0; hc_m = 0; err_exp = 0; last_tx_m = 0;
    tx_byte_m = 8'h00; rx_byte_m = 8'h00; exp_op = 0;
    prev_psel = 0; prev_done = 0; last_stat_cyc = -1;
  endtask

  // Slave, client driver and model, all stepped at the falling edge
  initial begin
    int          x_op, wcnt;
    logic [15:0] x_addr;
    logic        x_wr;
    logic [31:0] x_data, r;
    bit          new_x, cmpl, fail, rx_take, tx_load, dtx, drx;
    logic [2:0]  sv;
    logic [7:0]  rb;
    x_op = 0; wcnt = 0; x_addr = '0; x_wr = 0; x_data = '0;
    bus.pready = 0; bus.pslverr = 0; bus.prdata = '0;
    tx_valid = 0; tx_data = 8'h00; rx_ready = 0;
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_psel", bus.psel, 1'b0);
        model_reset();
        bus.pready = 0; bus.pslverr = 0; tx_valid = 0;
      end else begin
        chk("tx_ready", tx_ready, !tx_pend);
        chk("rx_valid", rx_valid, rx_held);
        if (rx_held) chk("rx_data", rx_data, rx_byte_m);
        chk("hostconn", hostconn, hc_m);
        chk("err", err, err_exp);
        err_exp = 0;
        if (prev_done) chk("psel_gap", bus.psel, 1'b0);
        new_x = bus.psel && (!prev_psel || prev_done);
        bus.pready = 0; bus.pslverr = 0;
        cmpl = 0; fail = 0;
        if (new_x) begin
          chk("setup_pen", bus.penable, 1'b0);
          x_addr = bus.paddr; x_wr = bus.pwrite; x_data = bus.pwdata;
          if (x_addr == VUART_ADDR_STAT && !x_wr) x_op = 0;
          else if (x_addr == VUART_ADDR_FIFO) x_op = x_wr ? 1 : 2;
          else x_op = 3;
          chk("op_order", x_op, exp_op);
          if (x_op == 1) chk("pwdata", x_data, {24'h0, tx_byte_m});
          if (x_op == 0) begin
            if (quiet && last_stat_cyc >= 0) chk("poll_period", cyc - last_stat_cyc, POLL + 3);
            last_stat_cyc = cyc;
          end
          wcnt = (wait_fixed >= 0) ? wait_fixed : $urandom_range(0, 3);
        end else if (bus.psel) begin
          chk("access_pen", bus.penable, 1'b1);
          chk("paddr_hold", bus.paddr, x_addr);
          chk("pwrite_hold", bus.pwrite, x_wr);
          chk("pwdata_hold", bus.pwdata, x_data);
          if (wcnt == 0) begin
            cmpl = 1;
            if (x_op == 1 && err_wr_once) begin fail = 1; err_wr_once = 0; end
            else if (err_rate != 0 && $urandom_range(0, err_rate - 1) == 0) fail = 1;
            bus.pready = 1;
            bus.pslverr = fail;
            r = $urandom;
            sv = stat_rand ? 3'($urandom_range(0, 7)) : stat_val;
            rb = rd_rand ? 8'($urandom_range(0, 255)) : rd_byte;
            bus.prdata = (x_op == 0) ? {r[31:3], sv} : {r[31:8], rb};
          end else begin
            wcnt--;
          end
        end
        prev_done = cmpl;
        prev_psel = bus.psel;

        rx_ready = (rx_mode == 0) ? 1'b0 : (rx_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        if (src_q.size() != 0 && (!tx_rand || $urandom_range(0, 3) != 0)) begin
          tx_valid = 1; tx_data = src_q[0];
        end else begin
          tx_valid = 0; tx_data = 8'($urandom_range(0, 255));
        end

        rx_take = rx_held && rx_ready;
        tx_load = tx_valid && !tx_pend;
        if (cmpl) begin
          if (fail) begin
            err_exp = 1; exp_op = 0; err_cnt++;
          end else begin
            case (x_op)
              0: begin
                stat_cnt++;
                hc_m = bus.prdata[2];
                dtx = bus.prdata[1] && tx_pend;
                drx = bus.prdata[0] && !rx_held;
                if (dtx && drx) exp_op = last_tx_m ? 2 : 1;
                else if (dtx) exp_op = 1;
                else if (drx) exp_op = 2;
                else exp_op = 0;
              end
              1: begin
                tx_pend = 0; wr_q.push_back(x_data[7:0]); last_tx_m = 1; exp_op = 0;
                ops_q.push_back(1);
              end
              default: begin
                rx_held = 1; rx_byte_m = bus.prdata[7:0]; last_tx_m = 0; exp_op = 0;
                rd_cnt++; ops_q.push_back(2);
              end
            endcase
          end
        end
        if (rx_take) rx_held = 0;
        if (tx_load) begin
          tx_pend = 1; tx_byte_m = src_q.pop_front();
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, nw, base;
    logic [7:0] sent[$];
    logic [7:0] b;
    rst_n = 0;
    cycles(3);
    chk("rst_penable", bus.penable, 1'b0);
    chk("rst_pwrite", bus.pwrite, 1'b0);
    chk("rst_paddr", bus.paddr, 16'h0);
    chk("rst_pwdata", bus.pwdata, 32'h0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h0);
    chk("rst_hostconn", hostconn, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1;

    // Idle polling with STAT=0
    quiet = 1; last_stat_cyc = -1; n = stat_cnt;
    cycles(50);
    chk("poll_count", (stat_cnt - n) >= 6, 1'b1);
    quiet = 0;

    // TX held back until TXRDY is seen
    src_q.push_back(8'h41);
    n = stat_cnt;
    for (int i = 0; i < 300 && stat_cnt < n + 3; i++) cycles(1);
    chk("tx_polls_seen", stat_cnt >= n + 3, 1'b1);
    chk("tx_held", tx_ready, 1'b0);
    nw = wr_q.size(); stat_val = 3'h2;
    for (int i = 0; i < 300 && wr_q.size() == nw; i++) cycles(1);
    chk("tx_wr_done", wr_q.size() > nw, 1'b1);
    if (wr_q.size() > nw) chk("tx_wr_byte", wr_q[nw], 8'h41);
    cycles(2);
    chk("tx_ready_back", tx_ready, 1'b1);

    // RX held while the client stalls
    stat_val = 3'h1; rd_byte = 8'h5A; rx_mode = 0;
    for (int i = 0; i < 300 && !rx_valid; i++) cycles(1);
    chk("rx_got", rx_valid, 1'b1);
    chk("rx_byte", rx_data, 8'h5A);
    n = rd_cnt;
    cycles(40);
    chk("rx_no_reread", rd_cnt, n);
    rx_mode = 1;
    for (int i = 0; i < 300 && rd_cnt == n; i++) cycles(1);
    chk("rx_resume", rd_cnt > n, 1'b1);

    // Both pending, wait states in every ACCESS: write/read/write
    stat_val = 3'h0; wait_fixed = 3;
    cycles(30);
    for (int i = 0; i < 4; i++) src_q.push_back(8'h10 + 8'(i));
    cycles(5);
    ops_q.delete(); stat_val = 3'h3;
    for (int i = 0; i < 1000 && ops_q.size() < 3; i++) cycles(1);
    chk("alt_ops", ops_q.size() >= 3, 1'b1);
    if (ops_q.size() >= 3) begin
      chk("alt_op0", ops_q[0], 1);
      chk("alt_op1", ops_q[1], 2);
      chk("alt_op2", ops_q[2], 1);
    end
    stat_val = 3'h2;
    for (int i = 0; i < 2000 && (src_q.size() != 0 || !tx_ready); i++) cycles(1);
    chk("alt_drained", tx_ready, 1'b1);

    // Failed FIFO write is retried with the same byte
    wait_fixed = 0; stat_val = 3'h2; cycles(10);
    n = err_cnt; nw = wr_q.size(); err_wr_once = 1;
    src_q.push_back(8'hC3);
    for (int i = 0; i < 500 && wr_q.size() == nw; i++) cycles(1);
    chk("slverr_count", err_cnt - n, 1);
    chk("retry_done", wr_q.size(), nw + 1);
    if (wr_q.size() > nw) chk("retry_byte", wr_q[nw], 8'hC3);

    // HOSTCONN follows STAT bit 2
    stat_val = 3'h4; cycles(25);
    chk("hostconn_set", hostconn, 1'b1);
    stat_val = 3'h0; cycles(25);
    chk("hostconn_clr", hostconn, 1'b0);

    // Randomized traffic
    stat_rand = 1; rd_rand = 1; wait_fixed = -1; err_rate = 8; rx_mode = 2; tx_rand = 1;
    base = wr_q.size();
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b); src_q.push_back(b);
    end
    for (int i = 0; i < 8000 && (src_q.size() != 0 || !tx_ready); i++) cycles(1);
    chk("rand_wr_count", wr_q.size() - base, 40);
    for (int i = 0; i < 40 && base + i < wr_q.size(); i++) chk("rand_wr_byte", wr_q[base + i], sent[i]);
    stat_rand = 0; rd_rand = 0; err_rate = 0; rx_mode = 1; tx_rand = 0; stat_val = 3'h0;
    cycles(20);

    // Asynchronous reset inside a write ACCESS
    wait_fixed = 5; stat_val = 3'h2;
    src_q.push_back(8'h99);
    for (int i = 0; i < 500 && !(bus.psel && bus.penable && bus.pwrite); i++) cycles(1);
    chk("wr_access_seen", bus.psel && bus.penable && bus.pwrite, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("arst_psel", bus.psel, 1'b0);
    chk("arst_penable", bus.penable, 1'b0);
    cycles(2);
    rst_n = 1;
    cycles(2);
    chk("arst_tx_ready", tx_ready, 1'b1);
    chk("arst_rx_valid", rx_valid, 1'b0);
    cycles(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
